// File: rtl/sram_pkg.sv
// Shared definitions for the board SRAM access controller: bus widths,
// FSM state encoding and the inactive byte-enable pattern.
package sram_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam logic [1:0] BE_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    TURN
  } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-client controller for the 256K x 16 asynchronous SRAM: one request at a
// time, strobes held for ACCESS_CYCLES, optional write turnaround, registered read data.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int TURN_CYCLES   = 1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iREQ,
  input  logic               iWR,
  input  logic [SRAM_AW-1:0] iADDR,
  input  logic [SRAM_DW-1:0] iWDATA,
  input  logic [1:0]         iBE_N,
  output logic               oACK,
  output logic [SRAM_DW-1:0] oRDATA,
  output logic               oRVALID,
  output logic               oBUSY,
  output logic [SRAM_AW-1:0] oS_ADDR,
  output logic [SRAM_DW-1:0] oS_DATA,
  input  logic [SRAM_DW-1:0] iS_DATA,
  output logic               oS_WE_N,
  output logic               oS_OE_N,
  output logic               oS_CE_N,
  output logic [1:0]         oS_BE_N
);

  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam int TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;

  sram_state_t        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      turn_q, turn_d;
  logic               wr_q;
  logic [1:0]         be_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] wdata_q;
  logic [SRAM_DW-1:0] rdata_q;
  logic               rvalid_q;
  logic               ce_n_q, oe_n_q, we_n_q;
  logic [1:0]         be_n_q;

  logic               ce_n_d, oe_n_d, we_n_d;
  logic [1:0]         be_n_d;
  logic               accept;
  logic               rd_done;

  // Reset gates the handshake so a held request is never acknowledged during reset.
  assign accept  = iREQ && !iRST && (state_q == IDLE);
  assign rd_done = (state_q == ACCESS) && !wr_q && (cnt_q == '0);

  // NOTE: every register uses <= so all of them update from pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      turn_q   <= '0;
      wr_q     <= 1'b0;
      be_q     <= BE_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= BE_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      turn_q   <= turn_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
      rvalid_q <= rd_done;
      if (rd_done) rdata_q <= iS_DATA;
      if (accept) begin
        wr_q    <= iWR;
        be_q    <= iBE_N;
        addr_q  <= iADDR;
        wdata_q <= iWDATA;
      end
    end
  end

  // NOTE: defaults first so every path assigns each signal and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    turn_d  = turn_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          cnt_d   = CW'(ACCESS_CYCLES - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (wr_q && (TURN_CYCLES > 0)) begin
            state_d = TURN;
            turn_d  = TW'(TURN_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TURN: begin
        if (turn_q == '0) state_d = IDLE;
        else              turn_d  = turn_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they are glitch-free.
  always_comb begin
    logic       acc_nxt;
    logic       wr_nxt;
    logic [1:0] be_nxt;
    acc_nxt = (state_d == ACCESS);
    wr_nxt  = accept ? iWR   : wr_q;
    be_nxt  = accept ? iBE_N : be_q;
    ce_n_d  = !acc_nxt;
    oe_n_d  = !(acc_nxt && !wr_nxt);
    we_n_d  = !(acc_nxt && wr_nxt);
    be_n_d  = acc_nxt ? be_nxt : BE_NONE;
  end

  assign oACK    = accept;
  assign oBUSY   = (state_q != IDLE);
  assign oRDATA  = rdata_q;
  assign oRVALID = rvalid_q;
  assign oS_ADDR = addr_q;
  assign oS_DATA = wdata_q;
  assign oS_CE_N = ce_n_q;
  assign oS_OE_N = oe_n_q;
  assign oS_WE_N = we_n_q;
  assign oS_BE_N = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM device, a cycle-window reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_sram_ctrl;
  import sram_pkg::*;

  localparam int AC    = 2;
  localparam int TC    = 1;
  localparam int DEPTH = 1 << SRAM_AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, wr;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be_n;
  logic        ack, rvalid, busy;
  logic [15:0] rdata, s_data, s_rdata;
  logic [17:0] s_addr;
  logic        s_we_n, s_oe_n, s_ce_n;
  logic [1:0]  s_be_n;

  logic        r1_req, r1_wr;
  logic [17:0] r1_addr;
  logic [15:0] r1_wdata;
  logic [1:0]  r1_be_n;
  logic        r1_ack, r1_rvalid, r1_busy;
  logic [15:0] r1_rdata, r1_s_data, r1_s_rdata;
  logic [17:0] r1_s_addr;
  logic        r1_s_we_n, r1_s_oe_n, r1_s_ce_n;
  logic [1:0]  r1_s_be_n;

  sram_ctrl #(.ACCESS_CYCLES(AC), .TURN_CYCLES(TC)) u_dut (
    .iCLK(clk), .iRST(rst), .iREQ(req), .iWR(wr), .iADDR(addr), .iWDATA(wdata),
    .iBE_N(be_n), .oACK(ack), .oRDATA(rdata), .oRVALID(rvalid), .oBUSY(busy),
    .oS_ADDR(s_addr), .oS_DATA(s_data), .iS_DATA(s_rdata), .oS_WE_N(s_we_n),
    .oS_OE_N(s_oe_n), .oS_CE_N(s_ce_n), .oS_BE_N(s_be_n)
  );

  sram_ctrl #(.ACCESS_CYCLES(1), .TURN_CYCLES(0)) u_dut1 (
    .iCLK(clk), .iRST(rst), .iREQ(r1_req), .iWR(r1_wr), .iADDR(r1_addr),
    .iWDATA(r1_wdata), .iBE_N(r1_be_n), .oACK(r1_ack), .oRDATA(r1_rdata),
    .oRVALID(r1_rvalid), .oBUSY(r1_busy), .oS_ADDR(r1_s_addr), .oS_DATA(r1_s_data),
    .iS_DATA(r1_s_rdata), .oS_WE_N(r1_s_we_n), .oS_OE_N(r1_s_oe_n),
    .oS_CE_N(r1_s_ce_n), .oS_BE_N(r1_s_be_n)
  );

  // Behavioural asynchronous SRAM device on the wrapper side.
  logic [15:0] sram    [DEPTH];
  logic [15:0] ref_mem [DEPTH];

  assign s_rdata    = (!s_ce_n && !s_oe_n) ? sram[s_addr] : 16'hDEAD;
  assign r1_s_rdata = (!r1_s_ce_n && !r1_s_oe_n) ? ~r1_s_addr[15:0] : 16'hDEAD;

  always @(posedge clk) begin
    if (!s_ce_n && !s_we_n) begin
      if (!s_be_n[0]) sram[s_addr][7:0]  <= s_data[7:0];
      if (!s_be_n[1]) sram[s_addr][15:8] <= s_data[15:8];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rv_count = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rvalid === 1'b1) rv_count <= rv_count + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted request owns absolute cycle windows.
  int          acc_s = 0, acc_e = -1, busy_e = -1, rv_c = -1;
  bit          m_valid = 0;
  logic        m_wr;
  logic [1:0]  m_be;
  logic [17:0] m_addr;
  logic [15:0] m_data, m_rdata, rv_data;

  always @(negedge clk) begin : model
    int   c;
    logic in_acc, busy_x, ack_x;
    c      = cyc;
    in_acc = (c >= acc_s) && (c <= acc_e);
    busy_x = (c >= acc_s) && (c <= busy_e);
    ack_x  = req && !rst && !busy_x;
    if (m_valid) begin
      if (c == rv_c) m_rdata = rv_data;
      check("m_ack",    ack,    ack_x);
      check("m_busy",   busy,   busy_x);
      check("m_ce_n",   s_ce_n, !in_acc);
      check("m_oe_n",   s_oe_n, !(in_acc && !m_wr));
      check("m_we_n",   s_we_n, !(in_acc && m_wr));
      check("m_be_n",   s_be_n, in_acc ? m_be : 2'b11);
      check("m_addr",   s_addr, m_addr);
      check("m_sdata",  s_data, m_data);
      check("m_rvalid", rvalid, c == rv_c);
      check("m_rdata",  rdata,  m_rdata);
    end
    if (rst) begin
      m_valid = 1;
      acc_s = 0; acc_e = -1; busy_e = -1; rv_c = -1;
      m_wr = 0; m_be = 2'b11; m_addr = '0; m_data = '0; m_rdata = '0;
    end else if (m_valid && ack_x) begin
      acc_s  = c + 1;
      acc_e  = c + AC;
      m_wr   = wr;
      m_be   = be_n;
      m_addr = addr;
      m_data = wdata;
      if (wr) begin
        busy_e = c + AC + TC;
        if (!be_n[0]) ref_mem[addr][7:0]  = wdata[7:0];
        if (!be_n[1]) ref_mem[addr][15:8] = wdata[15:8];
      end else begin
        busy_e  = c + AC;
        rv_c    = c + AC + 1;
        rv_data = ref_mem[addr];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int ac);
    ac = -1;
    for (int i = 0; i < 40 && ac < 0; i++) begin
      @(negedge clk);
      if (ack) ac = cyc;
    end
    check("ack_timeout", ac >= 0, 1'b1);
  endtask

  task automatic req0(input logic w, input logic [17:0] a, input logic [15:0] d,
                      input logic [1:0] be, output int ac);
    req = 1'b1; wr = w; addr = a; wdata = d; be_n = be;
    wait_ack(ac);
    tick(1);
    req = 1'b0;
  endtask

  task automatic wait_rv(output int rc, output logic [15:0] d);
    rc = -1;
    d  = '0;
    for (int i = 0; i < 20 && rc < 0; i++) begin
      @(negedge clk);
      if (rvalid) begin
        rc = cyc;
        d  = rdata;
      end
    end
    check("rvalid_timeout", rc >= 0, 1'b1);
    tick(1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          a, a2, rc, we_cnt, rvn0, start;
    logic [15:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1; req = 1'b1; wr = 1'b0; addr = '0; wdata = '0; be_n = 2'b11;
    r1_req = 1'b0; r1_wr = 1'b0; r1_addr = '0; r1_wdata = '0; r1_be_n = 2'b00;
    tick(1);

    // Reset held with a pending request.
    repeat (3) begin
      @(negedge clk);
      check("rst_ack",    ack,    1'b0);
      check("rst_ce_n",   s_ce_n, 1'b1);
      check("rst_oe_n",   s_oe_n, 1'b1);
      check("rst_we_n",   s_we_n, 1'b1);
      check("rst_be_n",   s_be_n, 2'b11);
      check("rst_rvalid", rvalid, 1'b0);
      tick(1);
    end
    rst = 1'b0; req = 1'b0;
    tick(1);

    // Full-word write: WE low for 2 cycles, then one TURN cycle.
    req0(1'b1, 18'h1A2B3, 16'hBEEF, 2'b00, a);
    we_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!s_we_n) we_cnt++;
      if (cyc == a + 3) begin
        check("turn_busy", busy, 1'b1);
        check("turn_we_n", s_we_n, 1'b1);
        check("turn_addr", s_addr, 18'h1A2B3);
      end
      if (cyc == a + 4) check("turn_done", busy, 1'b0);
    end
    check("we_low_cycles", we_cnt, 2);
    tick(1);

    // Read back.
    req0(1'b0, 18'h1A2B3, 16'h0000, 2'b00, a);
    wait_rv(rc, d);
    check("rd_latency", rc - a, 3);
    check("rd_data", d, 16'hBEEF);

    // Upper-byte-only write.
    req0(1'b1, 18'h00155, 16'h1234, 2'b00, a);
    req0(1'b1, 18'h00155, 16'hABCD, 2'b01, a);
    req0(1'b0, 18'h00155, 16'h0000, 2'b00, a);
    wait_rv(rc, d);
    check("byte_wr_data", d, 16'hAB34);

    // Back-to-back reads at the address extremes with iREQ held.
    req0(1'b1, 18'h3FFFF, 16'h5A5A, 2'b00, a);
    tick(4);
    rvn0 = rv_count;
    req = 1'b1; wr = 1'b0; addr = 18'h00000; be_n = 2'b00;
    wait_ack(a);
    tick(1);
    addr = 18'h3FFFF;
    wait_ack(a2);
    tick(1);
    req = 1'b0;
    tick(5);
    check("b2b_ack_spacing", a2 - a, 3);
    check("b2b_rvalid_count", rv_count - rvn0, 2);
    check("b2b_top_addr", s_addr, 18'h3FFFF);
    check("b2b_top_data", rdata, 16'h5A5A);

    // Reset in the first ACCESS cycle of a read.
    req0(1'b0, 18'h1A2B3, 16'h0000, 2'b00, a);
    check("mid_oe_active", s_oe_n, 1'b0);
    rvn0 = rv_count;
    rst = 1'b1;
    tick(1);
    check("mid_rst_ce_n", s_ce_n, 1'b1);
    check("mid_rst_oe_n", s_oe_n, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(3);
    check("mid_rst_no_rvalid", rv_count - rvn0, 0);
    start = cyc;
    req0(1'b0, 18'h00155, 16'h0000, 2'b00, a);
    check("mid_rst_ack_at", a - start, 0);
    wait_rv(rc, d);
    check("mid_rst_reread", d, 16'hAB34);

    // ACCESS_CYCLES = 1, TURN_CYCLES = 0 instance.
    r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 18'h00012;
    a = -1;
    for (int i = 0; i < 20 && a < 0; i++) begin
      @(negedge clk);
      if (r1_ack) a = cyc;
    end
    check("p1_rd_ack_timeout", a >= 0, 1'b1);
    tick(1);
    r1_req = 1'b0;
    rc = -1;
    for (int i = 0; i < 20 && rc < 0; i++) begin
      if (r1_rvalid) begin
        rc = cyc;
        d  = r1_rdata;
      end else begin
        @(negedge clk);
      end
    end
    check("p1_rd_latency", rc - a, 2);
    check("p1_rd_data", d, 16'hFFED);
    tick(1);

    r1_req = 1'b1; r1_wr = 1'b1; r1_addr = 18'h00005; r1_wdata = 16'h1111;
    a = -1;
    for (int i = 0; i < 20 && a < 0; i++) begin
      @(negedge clk);
      if (r1_ack) a = cyc;
    end
    tick(1);
    r1_addr = 18'h00006; r1_wdata = 16'h2222;
    a2 = -1;
    for (int i = 0; i < 20 && a2 < 0; i++) begin
      @(negedge clk);
      if (r1_ack) a2 = cyc;
    end
    tick(1);
    r1_req = 1'b0;
    check("p1_wr_ack_seen", (a >= 0) && (a2 >= 0), 1'b1);
    check("p1_wr_spacing", a2 - a, 2);

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
